// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: round-robin two-master arbiter in front of one peripheral bus slave.
// Define GPIO_ARB_TIMEOUT_EN to bound the slave wait and raise a sticky err on expiry.
module gpio_bus_arbiter #(
  parameter int size_addr = 1,
  parameter int timeout   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_read,
  input  logic                 m0_write,
  input  logic [size_addr-1:0] m0_address,
  input  logic [7:0]           m0_data_in,
  output logic [7:0]           m0_data_out,
  output logic                 m0_ready_r,
  output logic                 m0_ready_w,
  input  logic                 m1_read,
  input  logic                 m1_write,
  input  logic [size_addr-1:0] m1_address,
  input  logic [7:0]           m1_data_in,
  output logic [7:0]           m1_data_out,
  output logic                 m1_ready_r,
  output logic                 m1_ready_w,
  output logic                 s_read,
  output logic                 s_write,
  output logic [size_addr-1:0] s_address,
  output logic [7:0]           s_data_out,
  input  logic [7:0]           s_data_in,
  input  logic                 s_ready_r,
  input  logic                 s_ready_w,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic r_gnt, r_last, r_op_w;
  logic w_req0, w_req1, w_gnt, w_hit, w_exp;
  if (size_addr < 1 || timeout < 1 || timeout > 255) begin : g_bad_param
    $error("gpio_bus_arbiter: parameter out of range");
  end
  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;
  assign w_gnt  = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_hit  = r_op_w ? s_ready_w : s_ready_r;
  assign s_read  = (r_state == ISSUE) & ~r_op_w;
  assign s_write = (r_state == ISSUE) & r_op_w;
  assign m0_ready_r = (r_state == DONE) & ~r_gnt & ~r_op_w;
  assign m0_ready_w = (r_state == DONE) & ~r_gnt & r_op_w;
  assign m1_ready_r = (r_state == DONE) & r_gnt & ~r_op_w;
  assign m1_ready_w = (r_state == DONE) & r_gnt & r_op_w;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? ((w_req0 | w_req1) ? ISSUE : IDLE) :
             (r_state == ISSUE) ? WAIT :
             (r_state == WAIT)  ? ((w_hit | w_exp) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gnt       <= 1'b0;
      r_last      <= 1'b1;
      r_op_w      <= 1'b0;
      s_address   <= '0;
      s_data_out  <= 8'h00;
      m0_data_out <= 8'h00;
      m1_data_out <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (w_req0 | w_req1)) begin
        r_gnt      <= w_gnt;
        r_op_w     <= w_gnt ? m1_write : m0_write;
        s_address  <= w_gnt ? m1_address : m0_address;
        s_data_out <= w_gnt ? m1_data_in : m0_data_in;
      end
      // a forced completion of a read returns all-ones to the master
      if (r_state == WAIT && !r_op_w && (w_hit | w_exp)) begin
        if (r_gnt) m1_data_out <= w_hit ? s_data_in : 8'hFF;
        else m0_data_out <= w_hit ? s_data_in : 8'hFF;
      end
      if (r_state == DONE) r_last <= r_gnt;
    end
  end
`ifdef GPIO_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  assign w_exp = (r_cnt == 8'(timeout - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'h00;
      err   <= 1'b0;
    end else begin
      r_cnt <= (r_state == ISSUE) ? 8'h00 : (r_state == WAIT) ? r_cnt + 8'h01 : r_cnt;
      if (r_state == WAIT && w_exp && !w_hit) err <= 1'b1;
    end
  end
`else
  assign w_exp = 1'b0;
  assign err   = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed vector table plus contention, reset-in-WAIT and timeout sequences.
module tb_gpio_bus_arbiter;
  localparam int AW = 1;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [7:0] m0_data_in = 0, m1_data_in = 0;
  logic [7:0] m0_data_out, m1_data_out, s_data_out;
  logic m0_ready_r, m0_ready_w, m1_ready_r, m1_ready_w;
  logic s_read, s_write, err;
  logic [AW-1:0] s_address;
  logic [7:0] s_data_in = 8'h00;
  logic s_ready_r = 1'b0, s_ready_w = 1'b0, slave_en = 1'b1;
  logic [7:0] mem [2] = '{8'h00, 8'h3C};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  gpio_bus_arbiter #(.size_addr(AW), .timeout(4)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_data_in(m0_data_in),
    .m0_data_out(m0_data_out), .m0_ready_r(m0_ready_r), .m0_ready_w(m0_ready_w),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_data_in(m1_data_in),
    .m1_data_out(m1_data_out), .m1_ready_r(m1_ready_r), .m1_ready_w(m1_ready_w),
    .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_data_out(s_data_out),
    .s_data_in(s_data_in), .s_ready_r(s_ready_r), .s_ready_w(s_ready_w), .err(err)
  );

  // slave answers one cycle after each strobe
  always @(posedge clk) begin
    s_ready_r <= s_read & slave_en;
    s_ready_w <= s_write & slave_en;
    if (s_write) mem[s_address] <= s_data_out;
    if (s_read) s_data_in <= mem[s_address];
  end

  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [7:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [7:0] d1;
    logic [1:0] e_s; logic [AW-1:0] e_a; logic [7:0] e_sd;
    logic [3:0] e_rdy; logic [7:0] e_o0, e_o1;
  } vec_t;
  vec_t v [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rdy();
    return {m0_ready_r, m0_ready_w, m1_ready_r, m1_ready_w};
  endfunction

  task automatic drop();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic run_vec(input vec_t x, input int n);
    m0_read = x.r0; m0_write = x.w0; m0_address = x.a0; m0_data_in = x.d0;
    m1_read = x.r1; m1_write = x.w1; m1_address = x.a1; m1_data_in = x.d1;
    @(negedge clk);
    chk($sformatf("v%0d strobes", n), 32'({s_read, s_write}), 32'(x.e_s));
    chk($sformatf("v%0d s_address", n), 32'(s_address), 32'(x.e_a));
    if (x.e_s[0]) chk($sformatf("v%0d s_data_out", n), 32'(s_data_out), 32'(x.e_sd));
    chk($sformatf("v%0d early ready", n), 32'(rdy()), 0);
    @(negedge clk);
    chk($sformatf("v%0d wait ready", n), 32'(rdy()), 0);
    @(negedge clk);
    chk($sformatf("v%0d ready", n), 32'(rdy()), 32'(x.e_rdy));
    chk($sformatf("v%0d m0_data_out", n), 32'(m0_data_out), 32'(x.e_o0));
    chk($sformatf("v%0d m1_data_out", n), 32'(m1_data_out), 32'(x.e_o1));
    drop();
    @(negedge clk);
  endtask

  initial begin
    v[0] = '{0,1,0,8'hA5, 0,0,0,8'h00, 2'b01,0,8'hA5, 4'b0100, 8'h00,8'h00};
    v[1] = '{0,0,0,8'h00, 1,0,1,8'h00, 2'b10,1,8'h00, 4'b0010, 8'h00,8'h3C};
    v[2] = '{1,0,0,8'h00, 0,0,0,8'h00, 2'b10,0,8'h00, 4'b1000, 8'hA5,8'h3C};
    v[3] = '{0,0,0,8'h00, 1,1,0,8'h5A, 2'b01,0,8'h5A, 4'b0001, 8'hA5,8'h3C};
    v[4] = '{0,1,1,8'h11, 0,1,0,8'h22, 2'b01,1,8'h11, 4'b0100, 8'hA5,8'h3C};
    v[5] = '{1,0,1,8'h00, 0,1,1,8'h77, 2'b01,1,8'h77, 4'b0001, 8'hA5,8'h3C};
    v[6] = '{1,0,1,8'h00, 0,0,0,8'h00, 2'b10,1,8'h00, 4'b1000, 8'h77,8'h3C};
    v[7] = '{0,0,0,8'h00, 1,0,0,8'h00, 2'b10,0,8'h00, 4'b0010, 8'h77,8'h5A};
    v[8] = '{0,1,0,8'h99, 0,0,0,8'h00, 2'b01,0,8'h99, 4'b0100, 8'h77,8'h5A};
    @(negedge clk); @(negedge clk);
    reset = 0;
    chk("reset ready", 32'(rdy()), 0);
    chk("reset strobes", 32'({s_read, s_write}), 0);
    chk("reset bus", 32'({s_address, s_data_out}), 0);
    chk("reset data_out", 32'({m0_data_out, m1_data_out}), 0);
    chk("reset err", 32'(err), 0);
    for (int i = 0; i < 8; i++) run_vec(v[i], i);
    // continuous contention: alternating grants every 4 cycles, m0 first
    m0_write = 1; m0_address = 0; m0_data_in = 8'h01;
    m1_write = 1; m1_address = 1; m1_data_in = 8'h02;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("contention k%0d", k), 32'(rdy()),
          32'((k == 3 || k == 11) ? 4'b0100 : (k == 7 || k == 15) ? 4'b0001 : 4'b0000));
      if (k == 15) drop();
    end
    run_vec(v[8], 8);
    // reset while m1 write is in WAIT; last-served was m0 before reset
    m1_write = 1; m1_address = 0; m1_data_in = 8'h33;
    @(negedge clk);
    chk("rst seq s_write", 32'(s_write), 1);
    @(negedge clk);
    reset = 1; drop();
    @(negedge clk);
    reset = 0;
    chk("rst seq ready", 32'(rdy()), 0);
    chk("rst seq bus", 32'({s_read, s_write, s_address, s_data_out}), 0);
    chk("rst seq data_out", 32'({m0_data_out, m1_data_out, err}), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst seq quiet %0d", k), 32'({rdy(), s_read, s_write}), 0);
    end
    m0_write = 1; m0_address = 1; m0_data_in = 8'h44;
    m1_write = 1; m1_address = 0; m1_data_in = 8'h55;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("post-reset contention", 32'(rdy()), 32'(4'b0100));
    drop();
    @(negedge clk);
`ifdef GPIO_ARB_TIMEOUT_EN
    slave_en = 0;
    m0_read = 1; m0_address = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("timeout k%0d ready", k), 32'(rdy()), 32'((k == 6) ? 4'b1000 : 4'b0000));
    end
    chk("timeout data", 32'(m0_data_out), 32'h FF);
    chk("timeout err", 32'(err), 1);
    drop(); slave_en = 1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("err sticky", 32'(err), 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("err cleared", 32'(err), 0);
`else
    chk("err tied low", 32'(err), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
